// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the multi-cycle data-memory responder.
//   dmem_state_t  : responder FSM states
//   DMEM_LAT_MIN  : smallest legal request latency in cycles
//   DMEM_LAT_MAX  : largest legal request latency (the wait counter is 4 bits)
//   dmem_word_idx : converts a byte address to a word index of a given width
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_LAT_MIN = 1;
    localparam int DMEM_LAT_MAX = 15;

    // Byte address to 16-bit word index. Bit 0 selects the byte within a
    // word, and bits above the array depth are dropped, so addresses alias.
    function automatic logic [15:0] dmem_word_idx(input logic [15:0] byte_addr,
                                                  input int words_log2);
        logic [15:0] mask;
        mask = (16'd1 << words_log2) - 16'd1;
        return (byte_addr >> 1) & mask;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the memory stage and the data memory.
//   en       : request valid (requester -> memory)
//   wr       : 1 = store, 0 = load
//   addr     : byte address, expected to be even
//   data_in  : store data
//   stall    : memory busy, request not taken (memory -> requester)
//   done     : one-cycle completion pulse
//   err      : completed request was unaligned
//   data_out : load result, held between loads
// Modports: master = requester side, slave = memory side.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;

    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] data_out;

    modport master (
        output en,
        output wr,
        output addr,
        output data_in,
        input  stall,
        input  done,
        input  err,
        input  data_out
    );

    modport slave (
        input  en,
        input  wr,
        input  addr,
        input  data_in,
        output stall,
        output done,
        output err,
        output data_out
    );

endinterface

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-port 16-bit word array. Writes land on the rising clock edge; reads
// are combinational so the responder can capture the word on the same edge
// it enters its completion state. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Multi-cycle data memory for the memory stage. One request is accepted at a
// time; stall stays high until the request completes LATENCY cycles later with
// a single-cycle done pulse. Stores commit and loads are captured on the edge
// that enters DONE, followed by a one-cycle bubble back in IDLE.
//   LATENCY    : cycles from acceptance edge to the edge sampling done (1..15)
//   WORDS_LOG2 : log2 of array depth in 16-bit words
//   clk        : clock
//   rst        : asynchronous active-high reset (FSM, counter, latch, data_out)
//   bus        : request/response bundle (slave side)
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int WORDS_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    if (LATENCY < DMEM_LAT_MIN || LATENCY > DMEM_LAT_MAX) begin : g_lat_check
        $error("data_mem_responder: LATENCY %0d outside %0d..%0d",
               LATENCY, DMEM_LAT_MIN, DMEM_LAT_MAX);
    end

    // BUSY holds for cnt+1 cycles, so LATENCY-2 brings the DONE cycle in at
    // acceptance + LATENCY-1.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t             state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [WORDS_LOG2-1:0]   word_reg;
    logic                    wr_reg;
    logic [15:0]             data_reg;
    logic                    misalign_reg;
    logic [15:0]             data_out_reg;

    logic                    accept;
    logic                    enter_done;
    logic [WORDS_LOG2-1:0]   req_word;
    logic                    req_wr;
    logic [15:0]             req_data;
    logic                    req_misalign;
    logic                    array_we;
    logic [15:0]             array_rdata;

    assign accept = (state_reg == IDLE) && bus.en;

    // With LATENCY == 1 DONE is entered on the acceptance edge itself, before
    // the latch holds the request, so the live bus fields are used then.
    always_comb begin
        if (state_reg == IDLE) begin
            req_word     = WORDS_LOG2'(dmem_word_idx(bus.addr, WORDS_LOG2));
            req_wr       = bus.wr;
            req_data     = bus.data_in;
            req_misalign = bus.addr[0];
        end else begin
            req_word     = word_reg;
            req_wr       = wr_reg;
            req_data     = data_reg;
            req_misalign = misalign_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.en) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // DONE always exits to IDLE, so reaching DONE next means entering it now.
    assign enter_done = (state_next == DONE);
    assign array_we   = enter_done && req_wr && !req_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            word_reg     <= '0;
            wr_reg       <= 1'b0;
            data_reg     <= 16'h0000;
            misalign_reg <= 1'b0;
            data_out_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                word_reg     <= req_word;
                wr_reg       <= bus.wr;
                data_reg     <= bus.data_in;
                misalign_reg <= bus.addr[0];
            end
            if (enter_done) begin
                if (req_misalign) begin
                    data_out_reg <= 16'h0000;
                end else if (!req_wr) begin
                    data_out_reg <= array_rdata;
                end
            end
        end
    end

    dmem_array #(
        .ADDR_W (WORDS_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .waddr (req_word),
        .wdata (req_data),
        .raddr (req_word),
        .rdata (array_rdata)
    );

    assign bus.stall    = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.err      = (state_reg == DONE) && misalign_reg;
    assign bus.data_out = data_out_reg;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that answers the load/store requests issued by the memory stage. It accepts one request at a time and holds stall high while the request is in flight. After a fixed, parameterized latency it completes the write or returns read data with a one-cycle done pulse. It replaces the zero-latency data memory so the fetch/decode/memory/wb datapath can be exercised against realistic stalling memory.

## Interface
- LATENCY, 4, cycles from acceptance edge to the edge at which the requester samples done (legal 1..15)
- WORDS_LOG2, 8, log2 of array depth in 16-bit words
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- en  input  1  request valid; sampled only while stall is low
- wr  input  1  1 = store, 0 = load; qualified by en
- addr  input  16  byte address; must be even
- data_in  input  16  store data; qualified by en & wr
- stall  output  1  high while a request is in flight; new requests ignored
- done  output  1  one-cycle completion pulse
- err  output  1  high with done when the completed request was unaligned
- data_out  output  16  load result; valid when done & !wr of the completed request, held otherwise

## Operation
- FSM states: IDLE, BUSY, DONE. stall = (state != IDLE). done = (state == DONE).
- IDLE: if en, latch addr, wr, and data_in. Also latch misalign = addr[0]. If LATENCY == 1, go to DONE. Otherwise go to BUSY with cnt = LATENCY-2.
- BUSY: if cnt == 0, go to DONE, else decrement cnt. en is ignored.
- Entering DONE (same edge) with misalign = 0:
  - Store: write latched data to word addr[WORDS_LOG2:1].
  - Load: data_out <= array[addr[WORDS_LOG2:1]].
- Entering DONE with misalign = 1: no write. data_out <= 16'h0000. err is high during DONE.
- DONE: unconditionally return to IDLE. en in DONE is ignored (stall high). A one-cycle bubble exists between requests.
- Address bits above WORDS_LOG2 are ignored, so addresses alias modulo 2^(WORDS_LOG2+1) bytes.
- A load following a store to the same word returns the stored value (write commits before the next acceptance).
- Array contents are not reset. Only the FSM, cnt, latched request, and data_out are reset.
- The requester must hold en until it observes stall low. A request whose en drops while stall is high is simply not seen.

## Timing
- Reset values: state IDLE, cnt 0, stall 0, done 0, err 0, data_out 16'h0000.
- Reset asserted mid-operation: immediately returns to IDLE. The pending store is dropped (array unchanged). No done pulse is produced.
- Acceptance at edge t0:
  - stall is high in cycles t0..t0+LATENCY (inclusive of the DONE cycle).
  - done, err, and data_out are valid in the cycle after edge t0+LATENCY-1 and are sampled by the requester at edge t0+LATENCY.
  - A new request can be accepted no earlier than edge t0+LATENCY+1. Request-to-request throughput is LATENCY+1 cycles.
- cnt is 4 bits. The LATENCY range is checked by elaboration assertion.
- data_out is registered and changes only on the edge entering DONE.

## Structure
- Shared package dmem_pkg:
  - State enum typedef dmem_state_t {IDLE, BUSY, DONE}.
  - Constants DMEM_LAT_MIN = 1 and DMEM_LAT_MAX = 15.
- Sub-module dmem_array: single-port array with synchronous write (we, waddr, wdata) and combinational read (raddr → rdata).
- The top level holds the FSM, counter, request latch, and output register.

## Test plan
- Reset then idle, LATENCY=4: stall=0, done=0, err=0, data_out=0000 for 5 cycles.
- Store addr 16'h0010, data 16'hBEEF at edge t0, then load 16'h0010:
  - stall is high through t0+4.
  - done is sampled at t0+4 for the store.
  - The load is accepted at t0+5, and data_out=BEEF is sampled with done at t0+9.
- Unaligned load at 16'h0011: done=1 and err=1 at t0+4, data_out=0000. A prior store to 16'h0010 is unaffected (a subsequent load returns its value).
- en pulsed during BUSY and DONE with a store to 16'h0020: no array change. A subsequent load of 16'h0020 returns the prior contents.
- rst asserted at t0+2 of a store 16'h0030 ← 16'h1234:
  - stall and done drop immediately.
  - A later load of 16'h0030 does not return 1234.
- LATENCY=1 instance: store 16'h0002 ← 16'h00AA at t0, done at t0+1. Load accepted at t0+2 returns 00AA at t0+3. Load at 16'h0202 (WORDS_LOG2=8, aliases to word 1) also returns 00AA.
